// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader_pkg
//  Purpose  : Shared types and constants for the instruction-memory loader.
//             Holds the loader state encoding, the byte-counter width and the
//             length-field width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // Width of the byte position counter inside a 32-bit word (0..3).
  localparam int BYTE_CNT_W = 2;

  // Width of the image length field (word count N) and the word counter.
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CHK   = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : word_assembler
//  Purpose  : Collects bytes into a little-endian word. Each shifted byte
//             enters at the top and moves down, so after four shifts the
//             first byte received sits in bits [7:0].
//  Ports    : clk, rst       - clock, synchronous active-high reset
//             clear          - restart assembly (load start)
//             shift          - a data byte is accepted this cycle
//             byte_in[7:0]   - the byte being accepted
//             word[W-1:0]    - assembled word (valid the cycle after word_full)
//             word_full      - this shift completes the word (4th byte)
//  Revision : 1.0 - initial release
// ============================================================================
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [BYTE_CNT_W-1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (shift) begin
      word     <= {byte_in, word[WORD_W-1:8]};
      // Wraps from 3 back to 0, ready for the next word.
      byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
    end
  end

  assign word_full = shift && (byte_cnt == {BYTE_CNT_W{1'b1}});

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Boot-time instruction memory writer. Receives a byte stream
//             (16-bit LE word count, then N LE 32-bit words, then an optional
//             XOR checksum byte), writes each word to the instruction memory
//             and holds the core in reset until the image is fully written.
//  Config   : IMEM_LOADER_CHECKSUM_EN - when defined, a trailing checksum byte
//             (XOR of all payload bytes) is required; mismatch -> error.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             start              - begin a load (from IDLE, DONE or ERROR)
//             in_valid/in_data   - byte source
//             in_ready           - loader accepts a byte this cycle
//             mem_A/WD/WE/en     - instruction memory write port
//             core_hold          - keep core in reset
//             done / error       - sticky load status
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_CAPACITY = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0] mem_WD,
  output logic                  mem_WE,
  output logic                  mem_en,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [LEN_W-1:0] CAP = LEN_W'(MEM_CAPACITY);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_PAYLOAD = S_CHK;
`else
  localparam state_t AFTER_PAYLOAD = S_DONE;
`endif

  state_t state, state_next;

  logic [LEN_W-1:0]      len;
  logic [LEN_W-1:0]      word_cnt;
  logic [LEN_W-1:0]      len_full;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_full;
  logic                  accept;
  logic                  start_ok;
  logic                  shift;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] chk_acc;
`endif

  assign accept   = in_valid && in_ready;
  // start only takes effect in the resting states; mid-load it is ignored.
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign shift    = accept && (state == S_DATA);
  // Length as it will be once the high byte now on in_data is captured.
  assign len_full = {in_data, len[7:0]};

  word_assembler #(
    .WORD_W (DATA_WIDTH)
  ) u_word_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .shift     (shift),
    .byte_in   (in_data),
    .word      (word),
    .word_full (word_full)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mem_WE     = 1'b0;
    mem_en     = 1'b0;
    mem_WD     = '0;
    core_hold  = 1'b1;
    done       = 1'b0;
    error      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_ok) state_next = S_LEN0;
      end
      S_LEN0: begin
        in_ready = 1'b1;
        if (accept) state_next = S_LEN1;
      end
      S_LEN1: begin
        in_ready = 1'b1;
        if (accept) begin
          if (len_full > CAP)             state_next = S_ERROR;
          else if (len_full == '0)        state_next = AFTER_PAYLOAD;
          else                            state_next = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (word_full) state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_WE = 1'b1;
        mem_en = 1'b1;
        mem_WD = word;
        if ((word_cnt + LEN_W'(1)) == len) state_next = AFTER_PAYLOAD;
        else                               state_next = S_DATA;
      end
      S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready = 1'b1;
        if (accept) state_next = (in_data == chk_acc) ? S_DONE : S_ERROR;
`else
        // Unreachable without the checksum stage.
        state_next = S_IDLE;
`endif
      end
      S_DONE: begin
        done      = 1'b1;
        core_hold = 1'b0;
        if (start_ok) state_next = S_LEN0;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start_ok) state_next = S_LEN0;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Length capture, word counter and checksum accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      len      <= '0;
      word_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_acc  <= '0;
`endif
    end else begin
      if (start_ok) begin
        word_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_acc  <= '0;
`endif
      end
      if (accept && (state == S_LEN0)) len[7:0]  <= in_data;
      if (accept && (state == S_LEN1)) len[15:8] <= in_data;
      if (state == S_WRITE) word_cnt <= word_cnt + LEN_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (shift) chk_acc <= chk_acc ^ in_data;
`endif
    end
  end

  assign mem_A = DATA_WIDTH'(word_cnt);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Self-checking bench for imem_loader. A stream-level model
//             derives the expected memory writes and final status from each
//             byte stream; a monitor checks every write against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int CAP = 10;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic        mem_en;
  logic        core_hold;
  logic        done;
  logic        error;

  imem_loader #(
    .DATA_WIDTH   (32),
    .MEM_CAPACITY (CAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_A     (mem_A),
    .mem_WD    (mem_WD),
    .mem_WE    (mem_WE),
    .mem_en    (mem_en),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  logic [7:0]  stream[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every cycle, compare the write port with the model.
  initial begin
    logic prev_we;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      check("mem_en_eq_we", {31'd0, mem_en}, {31'd0, mem_WE});
      if (mem_WE !== 1'b1) check("wd_zero_idle", mem_WD, 32'd0);
      if (mem_WE === 1'b1) begin
        check("we_single_cycle", {31'd0, prev_we}, 32'd0);
        log_a.push_back(mem_A);
        log_d.push_back(mem_WD);
        if (exp_a.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got A=%h WD=%h expected no write", mem_A, mem_WD);
        end else begin
          check("write_addr", mem_A, exp_a.pop_front());
          check("write_data", mem_WD, exp_d.pop_front());
        end
      end
      prev_we = mem_WE;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      in_data  = b;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      got = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) check("byte_timeout", 32'd0, 32'd1);
  endtask

  function automatic void add_chk();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < stream.size(); i++) x ^= stream[i];
    if (CHK_EN) stream.push_back(x);
  endfunction

  // Stream-level model: derive writes, status and latency, then drive it.
  task automatic run_load(input bit gaps);
    int n;
    int nsend;
    int lat;
    bit err;
    logic [7:0] x;
    n   = int'({stream[1], stream[0]});
    err = (n > CAP);
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        exp_a.push_back(32'(i));
        exp_d.push_back({stream[5+4*i], stream[4+4*i], stream[3+4*i], stream[2+4*i]});
      end
      if (CHK_EN) begin
        x = 8'h00;
        for (int i = 2; i < 2 + 4*n; i++) x ^= stream[i];
        err = (stream[2+4*n] != x);
      end
    end
    nsend = (n > CAP) ? 2 : (2 + 4*n + (CHK_EN ? 1 : 0));
    lat   = ((n == 0) || (n > CAP) || CHK_EN) ? 1 : 2;
    start_pulse();
    for (int i = 0; i < nsend; i++) send_byte(stream[i], gaps);
    if (lat == 2) begin
      @(negedge clk);
      check("done_not_early", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    check("done",      {31'd0, done},      {31'd0, !err});
    check("error",     {31'd0, error},     {31'd0, err});
    check("core_hold", {31'd0, core_hold}, {31'd0, err});
    check("ready_end", {31'd0, in_ready},  32'd0);
    check("writes_all_seen", 32'(exp_a.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_mem_A",     mem_A,              32'd0);
    check("rst_mem_WD",    mem_WD,             32'd0);
    check("rst_mem_WE",    {31'd0, mem_WE},    32'd0);
    check("rst_mem_en",    {31'd0, mem_en},    32'd0);
    check("rst_core_hold", {31'd0, core_hold}, 32'd1);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_error",     {31'd0, error},     32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // N=2 at full rate, with literal pins on the written words
    log_a.delete(); log_d.delete();
    stream = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    add_chk();
    run_load(1'b0);
    check("n2_count", 32'(log_a.size()), 32'd2);
    if (log_a.size() == 2) begin
      check("n2_a0", log_a[0], 32'd0);
      check("n2_d0", log_d[0], 32'h11223344);
      check("n2_a1", log_a[1], 32'd1);
      check("n2_d1", log_d[1], 32'hDEADBEEF);
    end

    // Oversized image: start from DONE, error after LEN_HI, no writes
    log_a.delete(); log_d.delete();
    stream = '{8'h0B, 8'h00};
    run_load(1'b0);
    check("n11_no_write", 32'(log_a.size()), 32'd0);

    // N=2 with random source gaps: identical writes
    log_a.delete(); log_d.delete();
    stream = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    add_chk();
    run_load(1'b1);
    check("gap_count", 32'(log_a.size()), 32'd2);
    if (log_d.size() == 2) begin
      check("gap_d0", log_d[0], 32'h11223344);
      check("gap_d1", log_d[1], 32'hDEADBEEF);
    end

    // Single word, checksum good / bad
    log_a.delete(); log_d.delete();
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream = '{8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h04};
    run_load(1'b0);
    check("chk_ok_done", {31'd0, done}, 32'd1);
    stream = '{8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h05};
    run_load(1'b0);
    check("chk_bad_error", {31'd0, error}, 32'd1);
`else
    stream = '{8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    run_load(1'b0);
`endif
    if (log_d.size() > 0) check("n1_d0", log_d[0], 32'h01020304);

    // Reset after 3 data bytes aborts the load without a write
    log_a.delete(); log_d.delete();
    start_pulse();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready",  {31'd0, in_ready},  32'd0);
    check("abort_core_hold", {31'd0, core_hold}, 32'd1);
    check("abort_done",      {31'd0, done},      32'd0);
    @(posedge clk); #1;
    check("abort_in_ready2", {31'd0, in_ready},  32'd0);
    check("abort_no_write",  32'(log_a.size()),  32'd0);
    stream = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    add_chk();
    run_load(1'b0);
    check("reload_count", 32'(log_a.size()), 32'd2);

    // N=0: immediate completion, no writes; start in DONE restarts
    log_a.delete(); log_d.delete();
    stream = '{8'h00, 8'h00};
    add_chk();
    run_load(1'b0);
    check("n0_no_write", 32'(log_a.size()), 32'd0);
    start_pulse();
    check("restart_ready", {31'd0, in_ready},  32'd1);
    check("restart_hold",  {31'd0, core_hold}, 32'd1);
    check("restart_done",  {31'd0, done},      32'd0);
    // run_load's own start lands in LEN0 and must be ignored.
    stream = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    add_chk();
    run_load(1'b0);
    if (log_d.size() > 0) check("restart_d0", log_d[0], 32'h12345678);
    check("restart_count", 32'(log_a.size()), 32'd1);

    // A byte offered while in_ready is low must not be taken
    in_valid = 1'b1;
    in_data  = 8'h99;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("idle_done_kept", {31'd0, done}, 32'd1);
    check("idle_no_write",  32'(log_a.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
